// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared types and constants for the Ethernet transmit path
// Contents: arbiter state encoding, frame length limits, header length constants
// used by the frame generators, and a frame length legality helper.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_FIRST  = 3'd2,
        ST_STREAM = 3'd3,
        ST_GAP    = 3'd4
    } tx_state_t;

    localparam int ETH_MIN_LEN    = 60;
    localparam int ETH_MAX_LEN    = 1514;
    localparam int HEADER_MAC_LEN = 14;
    localparam int HEADER_IP_LEN  = 20;
    localparam int HEADER_UDP_LEN = 8;

    function automatic logic len_is_legal(input logic [15:0] len, input logic [15:0] max_len);
        return (len != 16'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr.sv
// rtl/eth_tx_arbiter_rr.sv - combinational round-robin winner selection
// Ports:
//   req  in  NUM_SRC  request vector
//   ptr  in  PTR_W    index of the highest-priority source this round
//   win  out NUM_SRC  one-hot winner (zero when no request)
//   any  out 1        at least one request present
module rr_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int PTR_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] win,
    output logic               any
);

    logic [NUM_SRC-1:0] w_mask;
    logic [NUM_SRC-1:0] w_masked;
    logic [NUM_SRC-1:0] w_sel;

    // Requests at or above the pointer take priority; if none, wrap to the
    // full request vector. The lowest set bit of the chosen vector wins.
    assign w_mask   = ~((NUM_SRC'(1) << ptr) - NUM_SRC'(1));
    assign w_masked = req & w_mask;
    assign w_sel    = (w_masked != '0) ? w_masked : req;
    assign win      = w_sel & (~w_sel + NUM_SRC'(1));
    assign any      = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin sharing of the MAC transmit port between frame sources
// Optional padding to the minimum frame length: ETH_TX_PAD_EN.
// Ports:
//   eth_tx_clk, eth_tx_rst        clock, synchronous active-high reset
//   src_req/src_len/src_data      per-source request, length, byte at tx_byte_idx
//   src_grant/src_done/src_err    per-source one-hot grant, end pulse, error pulse
//   tx_byte_idx                   byte index the granted source presents
//   eth_tx_data/_data_en/_ack     MAC transmit interface
//   busy, tx_frame_cnt            status: not idle, good frames sent
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int IFG_CYCLES  = 12,
    parameter int ACK_TIMEOUT = 1024,
    parameter int MAX_LEN     = ETH_MAX_LEN
) (
    input  logic                    eth_tx_clk,
    input  logic                    eth_tx_rst,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [16*NUM_SRC-1:0]   src_len,
    input  logic [8*NUM_SRC-1:0]    src_data,
    output logic [NUM_SRC-1:0]      src_grant,
    output logic [15:0]             tx_byte_idx,
    output logic [NUM_SRC-1:0]      src_done,
    output logic [NUM_SRC-1:0]      src_err,
    output logic [7:0]              eth_tx_data,
    output logic                    eth_tx_data_en,
    input  logic                    eth_tx_ack,
    output logic                    busy,
    output logic [15:0]             tx_frame_cnt
);

    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);

    localparam logic [15:0]      MAX_LEN16 = 16'(MAX_LEN);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IFG_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_SRC - 1);

    tx_state_t          r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [NUM_SRC-1:0] r_grant, w_grant_nxt;
    logic [15:0]        r_len, w_len_nxt;
    logic [15:0]        r_idx, w_idx_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_data_en, w_data_en_nxt;
    logic [NUM_SRC-1:0] r_done, w_done_nxt;
    logic [NUM_SRC-1:0] r_err, w_err_nxt;
    logic [TO_W-1:0]    r_to_cnt, w_to_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [15:0]        r_frame_cnt, w_frame_cnt_nxt;
`ifdef ETH_TX_PAD_EN
    // Real source length; bytes at or beyond it are padding.
    logic [15:0]        r_len_src, w_len_src_nxt;
`endif

    logic [NUM_SRC-1:0] w_win;
    logic               w_any;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_ptr_adv;
    logic [15:0]        w_win_len;
    logic [15:0]        w_eff_len;
    logic [7:0]         w_src_byte;
    logic [7:0]         w_byte;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req (src_req),
        .ptr (r_ptr),
        .win (w_win),
        .any (w_any)
    );

    always_comb begin
        w_win_idx = '0;
        w_win_len = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_win[i]) begin
                w_win_idx = PTR_W'(i);
                w_win_len = src_len[16*i +: 16];
            end
        end
    end

    assign w_ptr_adv = (w_win_idx == PTR_LAST) ? '0 : w_win_idx + PTR_W'(1);

    always_comb begin
        w_src_byte = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant[i]) begin
                w_src_byte = src_data[8*i +: 8];
            end
        end
    end

`ifdef ETH_TX_PAD_EN
    assign w_eff_len = (w_win_len < 16'(ETH_MIN_LEN)) ? 16'(ETH_MIN_LEN) : w_win_len;
    assign w_byte    = (r_idx >= r_len_src) ? 8'h00 : w_src_byte;
`else
    assign w_eff_len = w_win_len;
    assign w_byte    = w_src_byte;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_nxt     = r_grant;
        w_len_nxt       = r_len;
        w_idx_nxt       = r_idx;
        w_data_nxt      = r_data;
        w_data_en_nxt   = r_data_en;
        w_done_nxt      = '0;
        w_err_nxt       = '0;
        w_to_cnt_nxt    = r_to_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
`ifdef ETH_TX_PAD_EN
        w_len_src_nxt   = r_len_src;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_ptr_nxt = w_ptr_adv;
                    if (!len_is_legal(w_win_len, MAX_LEN16)) begin
                        w_done_nxt = w_win;
                        w_err_nxt  = w_win;
                    end else begin
                        w_grant_nxt = w_win;
                        w_len_nxt   = w_eff_len;
`ifdef ETH_TX_PAD_EN
                        w_len_src_nxt = w_win_len;
`endif
                        w_idx_nxt   = 16'd0;
                        w_state_nxt = ST_GRANT;
                    end
                end
            end

            ST_GRANT: begin
                w_data_nxt    = w_byte;
                w_data_en_nxt = 1'b1;
                w_idx_nxt     = 16'd1;
                w_to_cnt_nxt  = '0;
                w_state_nxt   = ST_FIRST;
            end

            ST_FIRST: begin
                if (eth_tx_ack) begin
                    if (r_len == 16'd1) begin
                        w_data_en_nxt   = 1'b0;
                        w_data_nxt      = 8'h00;
                        w_done_nxt      = r_grant;
                        w_grant_nxt     = '0;
                        w_idx_nxt       = 16'd0;
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                        w_gap_cnt_nxt   = '0;
                        w_state_nxt     = ST_GAP;
                    end else begin
                        w_data_nxt  = w_byte;
                        w_idx_nxt   = 16'd2;
                        w_state_nxt = ST_STREAM;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    // MAC never took the frame: abort without counting it.
                    w_data_en_nxt = 1'b0;
                    w_data_nxt    = 8'h00;
                    w_done_nxt    = r_grant;
                    w_err_nxt     = r_grant;
                    w_grant_nxt   = '0;
                    w_idx_nxt     = 16'd0;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_GAP;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end

            ST_STREAM: begin
                // r_idx has already run one past the byte on the bus, so
                // equality with the length means the last byte was just shown.
                if (r_idx == r_len) begin
                    w_data_en_nxt   = 1'b0;
                    w_data_nxt      = 8'h00;
                    w_done_nxt      = r_grant;
                    w_grant_nxt     = '0;
                    w_idx_nxt       = 16'd0;
                    w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    w_gap_cnt_nxt   = '0;
                    w_state_nxt     = ST_GAP;
                end else begin
                    w_data_nxt = w_byte;
                    w_idx_nxt  = r_idx + 16'd1;
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge eth_tx_clk) begin
        if (eth_tx_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_data_en   <= 1'b0;
            r_done      <= '0;
            r_err       <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_frame_cnt <= '0;
`ifdef ETH_TX_PAD_EN
            r_len_src   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_data      <= w_data_nxt;
            r_data_en   <= w_data_en_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
`ifdef ETH_TX_PAD_EN
            r_len_src   <= w_len_src_nxt;
`endif
        end
    end

    assign src_grant      = r_grant;
    assign tx_byte_idx    = r_idx;
    assign src_done       = r_done;
    assign src_err        = r_err;
    assign eth_tx_data    = r_data;
    assign eth_tx_data_en = r_data_en;
    assign busy           = (r_state != ST_IDLE);
    assign tx_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - directed self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

    localparam int NS  = 3;
    localparam int IFG = 12;
    localparam int ATO = 16;
    localparam int ML  = 1514;
`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic              eth_tx_clk = 1'b0;
    logic              eth_tx_rst = 1'b1;
    logic [NS-1:0]     src_req = '0;
    logic [16*NS-1:0]  src_len = '0;
    logic [8*NS-1:0]   src_data;
    logic [NS-1:0]     src_grant;
    logic [15:0]       tx_byte_idx;
    logic [NS-1:0]     src_done;
    logic [NS-1:0]     src_err;
    logic [7:0]        eth_tx_data;
    logic              eth_tx_data_en;
    logic              eth_tx_ack = 1'b0;
    logic              busy;
    logic [15:0]       tx_frame_cnt;

    int total = 0;
    int bad   = 0;

    int          done_cnt [NS];
    int          err_cnt  [NS];
    logic [7:0]  cap_q [$];
    int          len_q [$];
    int          gap_q [$];
    logic [NS-1:0] gnt_q [$];
    bit          prev_en = 1'b0;
    bit          have_prev = 1'b0;
    int          run = 0;
    int          low = 0;

    eth_tx_arbiter #(
        .NUM_SRC     (NS),
        .IFG_CYCLES  (IFG),
        .ACK_TIMEOUT (ATO),
        .MAX_LEN     (ML)
    ) dut (
        .eth_tx_clk     (eth_tx_clk),
        .eth_tx_rst     (eth_tx_rst),
        .src_req        (src_req),
        .src_len        (src_len),
        .src_data       (src_data),
        .src_grant      (src_grant),
        .tx_byte_idx    (tx_byte_idx),
        .src_done       (src_done),
        .src_err        (src_err),
        .eth_tx_data    (eth_tx_data),
        .eth_tx_data_en (eth_tx_data_en),
        .eth_tx_ack     (eth_tx_ack),
        .busy           (busy),
        .tx_frame_cnt   (tx_frame_cnt)
    );

    always #5 eth_tx_clk = ~eth_tx_clk;

    function automatic logic [7:0] fbyte(input int s, input int i);
        return 8'(i + s * 16 + 1);
    endfunction

    function automatic int eff(input int l);
        return (PAD && l < 60) ? 60 : l;
    endfunction

    function automatic logic [7:0] ebyte(input int s, input int l, input int p);
        return (p < l) ? fbyte(s, p) : 8'h00;
    endfunction

    always_comb begin
        src_data = '0;
        for (int s = 0; s < NS; s++) begin
            src_data[8*s +: 8] = fbyte(s, int'(tx_byte_idx));
        end
    end

    always @(negedge eth_tx_clk) begin
        if (eth_tx_rst) begin
            prev_en   <= 1'b0;
            have_prev <= 1'b0;
            run       <= 0;
            low       <= 0;
        end else begin
            if (eth_tx_data_en) begin
                cap_q.push_back(eth_tx_data);
                if (!prev_en) begin
                    gnt_q.push_back(src_grant);
                    if (have_prev) gap_q.push_back(low);
                    run <= 1;
                end else begin
                    run <= run + 1;
                end
            end else if (prev_en) begin
                len_q.push_back(run);
                have_prev <= 1'b1;
                low       <= 1;
            end else begin
                low <= low + 1;
            end
            for (int s = 0; s < NS; s++) begin
                if (src_done[s]) done_cnt[s] <= done_cnt[s] + 1;
                if (src_err[s])  err_cnt[s]  <= err_cnt[s] + 1;
            end
            prev_en <= eth_tx_data_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge eth_tx_clk);
        #1;
    endtask

    task automatic wait_en(input logic v, input int maxc, input string tag);
        int n = 0;
        while (eth_tx_data_en !== v && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 32'(eth_tx_data_en), 32'(v));
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic ack_pulse();
        eth_tx_ack = 1'b1;
        tick();
        eth_tx_ack = 1'b0;
    endtask

    task automatic clear_caps();
        cap_q.delete();
        len_q.delete();
        gap_q.delete();
        gnt_q.delete();
    endtask

    task automatic do_reset();
        eth_tx_rst = 1'b1;
        src_req    = '0;
        eth_tx_ack = 1'b0;
        tick();
        for (int s = 0; s < NS; s++) begin
            done_cnt[s] = 0;
            err_cnt[s]  = 0;
        end
        clear_caps();
        tick();
        tick();
        eth_tx_rst = 1'b0;
    endtask

    // Captured bytes of one frame: byte 0 repeated for hold+1 cycles, then bytes 1..eff-1.
    task automatic chk_frame(input string tag, input int s, input int l, input int hold);
        int e = eff(l);
        chk({tag, "_size"}, 32'(cap_q.size()), 32'(e + hold));
        if (cap_q.size() < e + hold) return;
        for (int p = 0; p <= hold; p++)
            chk($sformatf("%s_b0_%0d", tag, p), 32'(cap_q[p]), 32'(ebyte(s, l, 0)));
        for (int k = 1; k < e; k++)
            chk($sformatf("%s_b%0d", tag, k), 32'(cap_q[hold + k]), 32'(ebyte(s, l, k)));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(src_grant), 32'd0);
        chk("rst_idx", 32'(tx_byte_idx), 32'd0);
        chk("rst_done", 32'(src_done), 32'd0);
        chk("rst_err", 32'(src_err), 32'd0);
        chk("rst_data", 32'(eth_tx_data), 32'd0);
        chk("rst_en", 32'(eth_tx_data_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(tx_frame_cnt), 32'd0);
        do_reset();

        // Single source, len 42, ack after byte 0 has been held 4 cycles
        src_len[15:0] = 16'd42;
        src_req = 3'b001;
        tick();
        chk("t1_grant", 32'(src_grant), 32'b001);
        chk("t1_en_lat1", 32'(eth_tx_data_en), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_en_lat2", 32'(eth_tx_data_en), 32'd1);
        chk("t1_byte0", 32'(eth_tx_data), 32'(fbyte(0, 0)));
        src_req = 3'b000;
        tick();
        tick();
        tick();
        ack_pulse();
        wait_en(1'b0, 100, "t1_end");
        chk("t1_grant_clr", 32'(src_grant), 32'd0);
        chk("t1_done", 32'(done_cnt[0]), 32'd1);
        chk("t1_err", 32'(err_cnt[0]), 32'd0);
        chk("t1_cnt", 32'(tx_frame_cnt), 32'd1);
        chk("t1_len", 32'(len_q.size() > 0 ? len_q[0] : -1), 32'(eff(42) + 3));
        chk_frame("t1", 0, 42, 3);
        wait_idle(40, "t1_idle");

        // Round robin with all three requesting continuously
        do_reset();
        src_len = {16'd64, 16'd64, 16'd64};
        src_req = 3'b111;
        for (int f = 0; f < 4; f++) begin
            wait_en(1'b1, 60, "t2_start");
            ack_pulse();
            if (f == 3) src_req = 3'b000;
            wait_en(1'b0, 100, "t2_end");
        end
        wait_idle(40, "t2_idle");
        chk("t2_cnt", 32'(tx_frame_cnt), 32'd4);
        chk("t2_ngnt", 32'(gnt_q.size()), 32'd4);
        if (gnt_q.size() == 4) begin
            chk("t2_g0", 32'(gnt_q[0]), 32'b001);
            chk("t2_g1", 32'(gnt_q[1]), 32'b010);
            chk("t2_g2", 32'(gnt_q[2]), 32'b100);
            chk("t2_g3", 32'(gnt_q[3]), 32'b001);
        end
        chk("t2_ngap", 32'(gap_q.size()), 32'd3);
        // GAP cycles plus the IDLE and GRANT cycles before the next byte 0
        foreach (gap_q[i]) chk($sformatf("t2_gap%0d", i), 32'(gap_q[i]), 32'(IFG + 2));
        foreach (len_q[i]) chk($sformatf("t2_len%0d", i), 32'(len_q[i]), 32'd64);
        chk("t2_done0", 32'(done_cnt[0]), 32'd2);
        chk("t2_done1", 32'(done_cnt[1]), 32'd1);
        chk("t2_done2", 32'(done_cnt[2]), 32'd1);

        // Rejection of len 0 and len MAX_LEN+1, pointer advance past the rejected source
        do_reset();
        src_len = {16'd10, 16'd0, 16'd10};
        src_req = 3'b010;
        tick();
        chk("t3_done_z", 32'(src_done), 32'b010);
        chk("t3_err_z", 32'(src_err), 32'b010);
        chk("t3_en_z", 32'(eth_tx_data_en), 32'd0);
        chk("t3_busy_z", 32'(busy), 32'd0);
        src_len[31:16] = 16'd10;
        src_req = 3'b011;
        tick();
        chk("t3_ptr2", 32'(src_grant), 32'b001);
        src_req = 3'b000;
        wait_en(1'b1, 10, "t3_f1_start");
        ack_pulse();
        wait_en(1'b0, 100, "t3_f1_end");
        wait_idle(40, "t3_f1_idle");
        src_len[31:16] = 16'(ML + 1);
        src_req = 3'b010;
        tick();
        chk("t3_done_big", 32'(src_done), 32'b010);
        chk("t3_err_big", 32'(src_err), 32'b010);
        chk("t3_en_big", 32'(eth_tx_data_en), 32'd0);
        src_req = 3'b110;
        tick();
        chk("t3_ptr2b", 32'(src_grant), 32'b100);
        src_req = 3'b000;
        wait_en(1'b1, 10, "t3_f2_start");
        ack_pulse();
        wait_en(1'b0, 100, "t3_f2_end");
        wait_idle(40, "t3_f2_idle");
        chk("t3_frames", 32'(gnt_q.size()), 32'd2);
        chk("t3_done1", 32'(done_cnt[1]), 32'd2);
        chk("t3_err1", 32'(err_cnt[1]), 32'd2);
        chk("t3_cnt", 32'(tx_frame_cnt), 32'd2);

        // Ack never arrives
        do_reset();
        src_len[15:0] = 16'd20;
        src_req = 3'b001;
        tick();
        src_req = 3'b000;
        wait_en(1'b1, 10, "t4_start");
        wait_en(1'b0, 50, "t4_end");
        chk("t4_hold", 32'(len_q.size() > 0 ? len_q[0] : -1), 32'(ATO));
        chk("t4_done", 32'(done_cnt[0]), 32'd1);
        chk("t4_err", 32'(err_cnt[0]), 32'd1);
        chk("t4_cnt", 32'(tx_frame_cnt), 32'd0);
        wait_idle(40, "t4_idle");

        // Reset in the middle of a 100-byte frame, then a fresh frame
        do_reset();
        src_len[15:0] = 16'd100;
        src_req = 3'b001;
        tick();
        src_req = 3'b000;
        wait_en(1'b1, 10, "t5_start");
        ack_pulse();
        begin
            int n = 0;
            while (eth_tx_data !== fbyte(0, 20) && n < 100) begin
                tick();
                n++;
            end
        end
        chk("t5_byte20", 32'(eth_tx_data), 32'(fbyte(0, 20)));
        eth_tx_rst = 1'b1;
        tick();
        chk("t5_en", 32'(eth_tx_data_en), 32'd0);
        chk("t5_grant", 32'(src_grant), 32'd0);
        chk("t5_done", 32'(src_done), 32'd0);
        chk("t5_err", 32'(src_err), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        eth_tx_rst = 1'b0;
        tick();
        clear_caps();
        src_len[15:0] = 16'd5;
        src_req = 3'b001;
        tick();
        src_req = 3'b000;
        wait_en(1'b1, 10, "t5_f_start");
        ack_pulse();
        wait_en(1'b0, 100, "t5_f_end");
        chk_frame("t5", 0, 5, 0);
        chk("t5_fdone", 32'(done_cnt[0]), 32'd1);
        chk("t5_fcnt", 32'(tx_frame_cnt), 32'd1);
        wait_idle(40, "t5_idle");

        // Short frame with immediate ack: padded or exact length depending on build
        do_reset();
        src_len[15:0] = 16'd42;
        src_req = 3'b001;
        tick();
        src_req = 3'b000;
        wait_en(1'b1, 10, "t6_start");
        ack_pulse();
        wait_en(1'b0, 100, "t6_end");
        chk("t6_len", 32'(len_q.size() > 0 ? len_q[0] : -1), 32'(eff(42)));
        chk_frame("t6", 0, 42, 0);
        chk("t6_cnt", 32'(tx_frame_cnt), 32'd1);
        wait_idle(40, "t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
